// File: rtl/move_reg_bank.sv
// move_reg_bank: move-based register bank for the 16-bit datapath.
// Each accepted command copies one word from a source address to a
// destination address through a two-stage pipeline:
//   S1 holds the captured command and reads its source (with S2 forwarding),
//   S2 holds the read data and commits it at the following edge.
// A read of ALU_ANS waits in S1 until the external ALU result reflects the
// most recent operand writes (pending S2 write to X/Y, or ans_wait != 0).
module move_reg_bank #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 4,
    parameter int N_GPR   = 8,
    parameter int ALU_LAT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mv_valid,
    output logic              mv_ready,
    input  logic [ADDR_W-1:0] from_addr,
    input  logic [ADDR_W-1:0] to_addr,
    input  logic [DATA_W-1:0] input_reg,
    input  logic [DATA_W-1:0] alu_ans,
    output logic [DATA_W-1:0] alu_x,
    output logic [DATA_W-1:0] alu_y,
    output logic [DATA_W-1:0] out_reg,
    output logic              busy,
    output logic              err,
    input  logic              err_clr
);

    localparam int N_ADDR = 6 + N_GPR;
    localparam int WAIT_W = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;

    localparam logic [ADDR_W:0]   N_ADDR_L  = (ADDR_W + 1)'(N_ADDR);
    localparam logic [ADDR_W-1:0] A_ZERO    = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_INPUT   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_ALU_X   = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_ALU_Y   = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_ALU_ANS = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] A_OUT     = ADDR_W'(5);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(ALU_LAT);

    // Stage S1: captured command
    logic              s1_valid_q, s1_valid_d;
    logic [ADDR_W-1:0] s1_from_q, s1_from_d;
    logic [ADDR_W-1:0] s1_to_q, s1_to_d;

    // Stage S2: pending write (s2_we_q is cleared for illegal commands)
    logic              s2_valid_q, s2_valid_d;
    logic              s2_we_q, s2_we_d;
    logic [ADDR_W-1:0] s2_to_q, s2_to_d;
    logic [DATA_W-1:0] s2_data_q, s2_data_d;

    // Architectural registers
    logic [DATA_W-1:0] alu_x_q, alu_x_d;
    logic [DATA_W-1:0] alu_y_q, alu_y_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic [DATA_W-1:0] gpr_q [N_GPR];
    logic [DATA_W-1:0] gpr_d [N_GPR];

    logic [WAIT_W-1:0] ans_wait_q, ans_wait_d;
    logic              err_q, err_d;

    logic              s1_legal;
    logic              stall;
    logic              accept;
    logic [DATA_W-1:0] rd_data;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < N_ADDR_L;
    endfunction

    // Legality of the command in S1 and the ALU_ANS read-after-write stall
    always_comb begin
        s1_legal = in_range(s1_from_q) && in_range(s1_to_q) &&
                   (s1_to_q != A_ZERO) && (s1_to_q != A_INPUT) &&
                   (s1_to_q != A_ALU_ANS);
        stall    = s1_valid_q && (s1_from_q == A_ALU_ANS) &&
                   ((s2_valid_q && ((s2_to_q == A_ALU_X) || (s2_to_q == A_ALU_Y))) ||
                    (ans_wait_q != '0));
    end

    assign mv_ready = !stall;
    assign accept   = mv_valid && mv_ready;

    // Source read for S1; S2's pending write overrides the stale register value
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
        rd_data = '0;
        case (s1_from_q)
            A_ZERO:    rd_data = '0;
            A_INPUT:   rd_data = input_reg;
            A_ALU_X:   rd_data = alu_x_q;
            A_ALU_Y:   rd_data = alu_y_q;
            A_ALU_ANS: rd_data = alu_ans;
            A_OUT:     rd_data = out_q;
            default: begin
                for (int i = 0; i < N_GPR; i++) begin
                    if (s1_from_q == ADDR_W'(6 + i)) rd_data = gpr_q[i];
                end
            end
        endcase
        if (s2_we_q && (s2_to_q == s1_from_q)) rd_data = s2_data_q;
    end

    // Pipeline advance: S1 holds on stall and a bubble enters S2
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_from_d  = s1_from_q;
        s1_to_d    = s1_to_q;
        if (!stall) begin
            s1_valid_d = accept;
            if (accept) begin
                s1_from_d = from_addr;
                s1_to_d   = to_addr;
            end
        end
        s2_valid_d = s1_valid_q && !stall;
        s2_we_d    = s2_valid_d && s1_legal;
        s2_to_d    = s1_to_q;
        s2_data_d  = rd_data;
    end

    // Commit of S2's write, ALU settle counter and sticky error flag
    always_comb begin
        alu_x_d = alu_x_q;
        alu_y_d = alu_y_q;
        out_d   = out_q;
        gpr_d   = gpr_q;
        if (s2_we_q) begin
            case (s2_to_q)
                A_ALU_X: alu_x_d = s2_data_q;
                A_ALU_Y: alu_y_d = s2_data_q;
                A_OUT:   out_d   = s2_data_q;
                default: begin
                    for (int i = 0; i < N_GPR; i++) begin
                        if (s2_to_q == ADDR_W'(6 + i)) gpr_d[i] = s2_data_q;
                    end
                end
            endcase
        end

        if (s2_we_q && ((s2_to_q == A_ALU_X) || (s2_to_q == A_ALU_Y))) begin
            ans_wait_d = WAIT_LOAD;
        end else if (ans_wait_q != '0) begin
            ans_wait_d = ans_wait_q - WAIT_W'(1);
        end else begin
            ans_wait_d = ans_wait_q;
        end

        // An illegal command entering S2 sets err; that beats a same-cycle clear.
        err_d = err_q && !err_clr;
        if (s2_valid_d && !s1_legal) err_d = 1'b1;
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_from_q  <= '0;
            s1_to_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_we_q    <= 1'b0;
            s2_to_q    <= '0;
            s2_data_q  <= '0;
            alu_x_q    <= '0;
            alu_y_q    <= '0;
            out_q      <= '0;
            // NOTE: the GPR array is a small flop bank that must read 0 after reset, so it is reset like any other register rather than left as uninitialised RAM.
            gpr_q      <= '{default: '0};
            ans_wait_q <= '0;
            err_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every flop samples pre-edge values, independent of statement order.
            s1_valid_q <= s1_valid_d;
            s1_from_q  <= s1_from_d;
            s1_to_q    <= s1_to_d;
            s2_valid_q <= s2_valid_d;
            s2_we_q    <= s2_we_d;
            s2_to_q    <= s2_to_d;
            s2_data_q  <= s2_data_d;
            alu_x_q    <= alu_x_d;
            alu_y_q    <= alu_y_d;
            out_q      <= out_d;
            gpr_q      <= gpr_d;
            ans_wait_q <= ans_wait_d;
            err_q      <= err_d;
        end
    end

    assign alu_x   = alu_x_q;
    assign alu_y   = alu_y_q;
    assign out_reg = out_q;
    assign err     = err_q;
    assign busy    = s1_valid_q || s2_valid_q || (ans_wait_q != '0);

endmodule

// File: tb/tb_move_reg_bank.sv
// tb_move_reg_bank: scoreboard bench for move_reg_bank.
// dut0 (ALU_LAT=0, combinational adder) takes directed and random moves; a
// sequential register-file model predicts each move's result in issue order,
// and a monitor pops predictions as moves commit and compares the visible
// registers. dut2 (ALU_LAT=2, two-cycle adder) covers the longer stall.
module tb_move_reg_bank;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int NG = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- dut0: ALU_LAT = 0 ----------------
    logic          mv_valid, mv_ready, busy, err, err_clr;
    logic [AW-1:0] from_addr, to_addr;
    logic [DW-1:0] input_reg, alu_ans, alu_x, alu_y, out_reg;

    assign alu_ans = alu_x + alu_y;

    move_reg_bank #(.DATA_W(DW), .ADDR_W(AW), .N_GPR(NG), .ALU_LAT(0)) dut0 (
        .clk(clk), .rst(rst), .mv_valid(mv_valid), .mv_ready(mv_ready),
        .from_addr(from_addr), .to_addr(to_addr), .input_reg(input_reg),
        .alu_ans(alu_ans), .alu_x(alu_x), .alu_y(alu_y), .out_reg(out_reg),
        .busy(busy), .err(err), .err_clr(err_clr)
    );

    // ---------------- dut2: ALU_LAT = 2 ----------------
    logic          mv_valid_l2, mv_ready_l2, busy_l2, err_l2, err_clr_l2;
    logic [AW-1:0] from_addr_l2, to_addr_l2;
    logic [DW-1:0] input_reg_l2, alu_ans_l2, alu_x_l2, alu_y_l2, out_reg_l2;
    logic [DW-1:0] ans_d1, ans_d2;

    // External ALU whose result settles two cycles after an operand change.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ans_d1 <= '0;
            ans_d2 <= '0;
        end else begin
            ans_d1 <= alu_x_l2 + alu_y_l2;
            ans_d2 <= ans_d1;
        end
    end
    assign alu_ans_l2 = ans_d2;

    move_reg_bank #(.DATA_W(DW), .ADDR_W(AW), .N_GPR(NG), .ALU_LAT(2)) dut2 (
        .clk(clk), .rst(rst), .mv_valid(mv_valid_l2), .mv_ready(mv_ready_l2),
        .from_addr(from_addr_l2), .to_addr(to_addr_l2), .input_reg(input_reg_l2),
        .alu_ans(alu_ans_l2), .alu_x(alu_x_l2), .alu_y(alu_y_l2), .out_reg(out_reg_l2),
        .busy(busy_l2), .err(err_l2), .err_clr(err_clr_l2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          to;
        logic [DW-1:0] data;
        bit          legal;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] ref_mem [16];
    logic [DW-1:0] next_in;
    bit            pend;
    int            pend_f, pend_t;

    function automatic bit ref_legal(input int f, input int t);
        return (f < 6 + NG) && (t < 6 + NG) && (t != 0) && (t != 1) && (t != 4);
    endfunction

    task automatic ref_reset();
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        exp_q.delete();
        pend = 1'b0;
    endtask

    // Sequential semantics: each move sees every earlier move's result.
    task automatic model_apply(input int f, input int t);
        logic [DW-1:0] v;
        bit ok;
        ok = ref_legal(f, t);
        case (f)
            0:       v = '0;
            1:       v = input_reg;
            4:       v = ref_mem[2] + ref_mem[3];
            default: v = ref_mem[f];
        endcase
        if (ok) ref_mem[t] = v;
        exp_q.push_back('{to: t, data: v, legal: ok});
    endtask

    // One cycle of dut0 stimulus, entered and left 1 time unit after a rising edge.
    // INPUT is sampled in the cycle after acceptance, so the previously accepted
    // move is resolved against the input value driven in this cycle.
    task automatic step(input bit v, input int f, input int t, output bit acc);
        input_reg = next_in;
        if (pend) model_apply(pend_f, pend_t);
        mv_valid  = v;
        from_addr = AW'(f);
        to_addr   = AW'(t);
        acc       = v && mv_ready;
        pend      = acc;
        pend_f    = f;
        pend_t    = t;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bit a;
        repeat (n) step(1'b0, 0, 0, a);
    endtask

    task automatic issue(input int f, input int t, output int stalls);
        bit a;
        a = 1'b0;
        stalls = 0;
        for (int i = 0; i < 32 && !a; i++) begin
            step(1'b1, f, t, a);
            if (!a) stalls++;
        end
        check($sformatf("accept_%0d_to_%0d", f, t), 32'(a), 32'd1);
    endtask

    task automatic step2(input bit v, input int f, input int t, output bit acc);
        mv_valid_l2  = v;
        from_addr_l2 = AW'(f);
        to_addr_l2   = AW'(t);
        acc          = v && mv_ready_l2;
        @(posedge clk);
        #1;
    endtask

    task automatic issue2(input int f, input int t, output int stalls);
        bit a;
        a = 1'b0;
        stalls = 0;
        for (int i = 0; i < 32 && !a; i++) begin
            step2(1'b1, f, t, a);
            if (!a) stalls++;
        end
        check($sformatf("l2_accept_%0d_to_%0d", f, t), 32'(a), 32'd1);
    endtask

    // ---------------- monitor ----------------
    // Tracks pipeline occupancy from the handshake: a move stays in S1 while
    // mv_ready is low, then spends one cycle in S2 and commits.
    initial begin : monitor
        bit m_s1, m_s2n, m_s2;
        logic [DW-1:0] mon_x, mon_y, mon_out;
        exp_t e;
        m_s1 = 0; m_s2n = 0; m_s2 = 0;
        mon_x = '0; mon_y = '0; mon_out = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_s1 = 0; m_s2n = 0; m_s2 = 0;
                mon_x = '0; mon_y = '0; mon_out = '0;
            end else begin
                if (m_s2) begin
                    check("sb_queue_nonempty", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        if (e.legal) begin
                            if (e.to == 2) mon_x = e.data;
                            if (e.to == 3) mon_y = e.data;
                            if (e.to == 5) mon_out = e.data;
                        end else begin
                            check("sb_err_on_illegal", 32'(err), 32'd1);
                        end
                        check("sb_alu_x", 32'(alu_x), 32'(mon_x));
                        check("sb_alu_y", 32'(alu_y), 32'(mon_y));
                        check("sb_out_reg", 32'(out_reg), 32'(mon_out));
                    end
                end
                m_s2  = m_s2n;
                m_s2n = m_s1 && mv_ready;
                if (mv_ready) m_s1 = mv_valid;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        int s, s1, s2, s3;
        bit a;
        rst = 1'b1;
        mv_valid = 0; from_addr = '0; to_addr = '0; input_reg = '0; err_clr = 0;
        mv_valid_l2 = 0; from_addr_l2 = '0; to_addr_l2 = '0; input_reg_l2 = 16'd5; err_clr_l2 = 0;
        next_in = '0;
        ref_reset();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_alu_x", 32'(alu_x), 32'd0);
        check("rst_alu_y", 32'(alu_y), 32'd0);
        check("rst_out_reg", 32'(out_reg), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mv_ready", 32'(mv_ready), 32'd1);
        @(posedge clk);
        #1;

        // Basic move, then operands and ALU result read
        next_in = 16'd1;
        issue(1, 6, s1);
        issue(6, 2, s1);
        issue(6, 3, s2);
        issue(4, 5, s3);
        check("no_stall_before_ans_read", 32'(s1 + s2 + s3), 32'd0);
        issue(6, 7, s);
        check("stall_after_ans_read_lat0", 32'(s), 32'd1);
        idle(4);
        check("basic_alu_x", 32'(alu_x), 32'd1);
        check("basic_out_reg", 32'(out_reg), 32'd2);

        // Forwarding chain without stall
        next_in = 16'h1234;
        issue(1, 6, s1);
        issue(6, 7, s2);
        issue(7, 5, s3);
        check("fwd_no_stall", 32'(s1 + s2 + s3), 32'd0);
        idle(2);
        check("fwd_out_reg", 32'(out_reg), 32'h1234);

        // Illegal destination ALU_ANS
        issue(6, 4, s);
        idle(3);
        check("ill_to4_err", 32'(err), 32'd1);
        check("ill_to4_out", 32'(out_reg), 32'h1234);
        check("ill_to4_x", 32'(alu_x), 32'd1);
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        check("err_clr", 32'(err), 32'd0);

        // Illegal source address 15
        issue(15, 5, s);
        idle(3);
        check("ill_from15_err", 32'(err), 32'd1);
        check("ill_from15_out", 32'(out_reg), 32'h1234);

        // Write to ZERO must not stick
        issue(6, 0, s);
        issue(0, 2, s);
        idle(3);
        check("zero_stays_zero", 32'(alu_x), 32'd0);
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        check("err_clr_again", 32'(err), 32'd0);

        // Randomized moves
        for (int i = 0; i < 500; i++) begin
            int f, t;
            bit v;
            v = ($urandom_range(0, 3) != 0);
            f = $urandom_range(0, 15);
            if ($urandom_range(0, 3) == 0) f = 4;
            t = $urandom_range(0, 15);
            next_in = DW'($urandom);
            step(v, f, t, a);
        end
        idle(8);
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        check("drain_busy", 32'(busy), 32'd0);

        // Reset while a move is in flight
        next_in = 16'h0055;
        issue(1, 5, s);
        idle(3);
        check("pre_reset_out", 32'(out_reg), 32'h0055);
        next_in = 16'd7;
        issue(1, 5, s);
        idle(1);
        rst = 1'b1;
        mv_valid = 1'b0;
        ref_reset();
        #1;
        check("midrst_out_reg", 32'(out_reg), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(3);
        check("midrst_out_after", 32'(out_reg), 32'd0);
        check("midrst_busy_after", 32'(busy), 32'd0);

        // ALU_LAT = 2 build
        issue2(1, 6, s);
        issue2(6, 2, s);
        issue2(4, 5, s);
        issue2(6, 7, s);
        check("stall_after_ans_read_lat2", 32'(s), 32'd3);
        mv_valid_l2 = 1'b0;
        repeat (4) step2(1'b0, 0, 0, a);
        check("l2_alu_x", 32'(alu_x_l2), 32'd5);
        check("l2_alu_ans", 32'(alu_ans_l2), 32'd5);
        check("l2_out_reg", 32'(out_reg_l2), 32'd5);
        check("l2_busy", 32'(busy_l2), 32'd0);
        check("l2_err", 32'(err_l2), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
